// File: rtl/crypto_wallet2_prng_pkg.sv
// Shared types, constants and the xorshift32 step function for the seed PRNG.
package crypto_wallet2_prng_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } prng_state_t;

    localparam logic [31:0] ZERO_SUB_DEFAULT = 32'hA5A5_5A5A;

    function automatic logic [31:0] xorshift32_step(input logic [31:0] x);
        logic [31:0] t;
        t = x ^ (x << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

endpackage

// File: rtl/crypto_wallet2_xorshift32_step.sv
// Combinational single xorshift32 step.
module crypto_wallet2_xorshift32_step
    import crypto_wallet2_prng_pkg::*;
(
    input  logic [31:0] state_in,
    output logic [31:0] state_out
);

    assign state_out = xorshift32_step(state_in);

endmodule

// File: rtl/crypto_wallet2_seed_prng.sv
// Seed-change detecting xorshift32 generator with warm-up, delivering words on a valid/ready stream.
module crypto_wallet2_seed_prng
    import crypto_wallet2_prng_pkg::*;
#(
    parameter int unsigned WARMUP   = 4,
    parameter logic [31:0] ZERO_SUB = ZERO_SUB_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] seed_in,
    output logic [31:0] rnd_data,
    output logic        rnd_valid,
    input  logic        rnd_ready,
    output logic        seeded,
    output logic [15:0] word_count
);

    localparam int unsigned WCW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam logic [WCW-1:0] WARM_LAST = (WARMUP > 0) ? WCW'(WARMUP - 1) : '0;
    localparam prng_state_t LOAD_STATE = (WARMUP > 0) ? ST_WARMUP : ST_RUN;
    localparam logic LOAD_VALID = (WARMUP == 0);

    prng_state_t    state;
    logic [31:0]    seed_q;
    logic [31:0]    x;
    logic [WCW-1:0] warm_cnt;
    logic [31:0]    step_x;
    logic [31:0]    load_x;
    logic           load;

    // Any difference from the last captured seed is a software reseed.
    assign load   = (seed_in != seed_q);
    assign load_x = (seed_in == 32'd0) ? ZERO_SUB : seed_in;

    crypto_wallet2_xorshift32_step u_step (
        .state_in  (x),
        .state_out (step_x)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            seed_q     <= '0;
            x          <= '0;
            warm_cnt   <= '0;
            word_count <= '0;
            seeded     <= 1'b0;
            rnd_valid  <= 1'b0;
            rnd_data   <= '0;
        end else if (load) begin
            // A reseed overrides any handshake in the same cycle.
            seed_q     <= seed_in;
            x          <= load_x;
            warm_cnt   <= '0;
            word_count <= '0;
            seeded     <= 1'b1;
            state      <= LOAD_STATE;
            rnd_valid  <= LOAD_VALID;
            rnd_data   <= LOAD_VALID ? load_x : 32'd0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                end
                ST_WARMUP: begin
                    x        <= step_x;
                    warm_cnt <= warm_cnt + WCW'(1);
                    if (warm_cnt == WARM_LAST) begin
                        state     <= ST_RUN;
                        rnd_valid <= 1'b1;
                        rnd_data  <= step_x;
                    end
                end
                ST_RUN: begin
                    if (rnd_valid && rnd_ready) begin
                        x          <= step_x;
                        rnd_data   <= step_x;
                        word_count <= word_count + 16'd1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    rnd_valid <= 1'b0;
                    rnd_data  <= '0;
                end
            endcase
        end
    end

endmodule
